vga_rx_monitor: RTL
===================

// Module: vga_rx_monitor
// PURPOSE
// - Receiving end of the VGA pixel stream we drive off-chip: decodes VGA_CLK/HS/VS/BLANK_N/RGB
//   back into pixel coordinates, checks frame geometry, captures one probe pixel per frame.
// - Sits beside the top-level VGA output (loopback on-chip, or on external capture pins).
// - Used for self-test of the game renderer and in benches as the synthesizable scoreboard.
// PARAMETERS
// - H_ACTIVE   640  active pixels per line (BLANK_N high)
// - V_ACTIVE   480  active lines per frame
// - SYNC_LOW   1    1: HS/VS active-low (640x480@60), 0: active-high
// - CNT_W      16   width of frame_count
// PORTS
// - clk          in   1   system clock, 50 MHz
// - reset        in   1   asynchronous, active-low reset
// - vga_clk      in   1   pixel clock (clk/2); rising edge = pixel sample point
// - vga_hs       in   1   horizontal sync
// - vga_vs       in   1   vertical sync
// - vga_blank_n  in   1   1 = active video
// - vga_r/g/b    in   8   colour components (3 ports)
// - probe_x      in   10  column to capture; sampled at frame_start
// - probe_y      in   10  row to capture; sampled at frame_start
// - pix_valid    out  1   1-clk pulse: pix_x/pix_y/pix_rgb hold a decoded active pixel
// - pix_x        out  10  column of current pixel, 0..H_ACTIVE-1
// - pix_y        out  10  row of current pixel, 0..V_ACTIVE-1
// - pix_rgb      out  24  {r,g,b} of current pixel
// - frame_start  out  1   1-clk pulse on VS assertion edge
// - locked       out  1   1 = last full frame had correct geometry
// - probe_rgb    out  24  captured colour at (probe_x,probe_y); held until next capture
// - probe_done   out  1   1-clk pulse when probe_rgb updates
// - frame_count  out  CNT_W  complete good frames since lock, wraps
// - err_count    out  8   geometry errors, saturates at 255
// BEHAVIOUR
// - Reset (reset=0): all outputs 0, FSM=SEARCH, counters 0; takes effect immediately, mid-frame too.
// - Inputs registered once in clk; strobe = vga_clk_q & ~vga_clk_qq. All decode on strobe only.
// - pix_valid/pix_* asserted 2 clk after the vga_clk rising edge that carried the pixel.
// - Sync assertion = vs/hs edge to active level per SYNC_LOW.
// - x_cnt: +1 per strobe with blank_n=1; on blank_n 1->0: check x_cnt==H_ACTIVE, clear, y_cnt+1.
// - y_cnt: cleared on VS assertion, after checking y_cnt==V_ACTIVE.
// - FSM SEARCH: ignore data; on VS assertion -> ALIGN.
// - FSM ALIGN: count one full frame; at next VS assertion, geometry ok -> LOCKED (locked=1),
//   else err_count+1, stay ALIGN.
// - FSM LOCKED: pix_valid pulses per active pixel; frame_start pulses; frame_count+1 per good
//   frame; any bad line or frame -> err_count+1, locked=0, pix_valid suppressed, -> ALIGN.
// - x_cnt reaching H_ACTIVE with blank_n still 1: error at once, x_cnt held (no wrap).
// - Probe: latched at frame_start; on pixel with x,y match, probe_rgb<=rgb, probe_done pulses,
//   once per frame, LOCKED only. Out-of-range probe: never fires, no error.
// - VS assertion on the same strobe as blank_n 1->0: line check first, then frame check.
// - vga_clk stopped: no strobes, all state frozen; no timeout in this block.
// STRUCTURE
// - vga_timing.vh: shared localparams H_ACTIVE/V_ACTIVE/H_TOTAL=800/V_TOTAL=525, FSM codes;
//   also used by the vga timing generator.
// - Sub-module vga_rx_strobe: 2-flop input register, vga_clk edge detect, sync/blank edges.
// - Top body: FSM, x/y counters, geometry checks, probe capture, status counters.
// TESTING
// - Drive from vga timing generator, pixel rgb={x[7:0],y[7:0],8'h5A} -> locked=1 after 2nd VS,
//   every pix_valid shows matching rgb, 307200 pix_valid per frame.
// - probe=(639,479), rgb={8'h7F,8'hDF,8'h5A} -> probe_done once per frame, probe_rgb=24'h7FDF5A.
// - Inject one 639-pixel line mid-frame -> err_count=1, locked=0 at once, relocks after 2 VS.
// - Frame of 479 lines -> err_count+1, frame_count unchanged, locked=0 at that VS.
// - reset low mid-line at (x=300,y=200) -> all outputs 0 next clk; release -> SEARCH, relock.
// - 65536 good frames (CNT_W=16) -> frame_count wraps to 0; 300 bad frames -> err_count=255.

Source files
------------

// File: rtl/vga_rx_monitor_pkg.sv
// Shared timing constants, FSM encoding and small helpers for the VGA receive monitor.
package vga_rx_monitor_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int H_TOTAL      = 800;
    localparam int V_TOTAL      = 525;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } rx_state_e;

    // Saturating increment for the 8-bit error counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

endpackage

// File: rtl/vga_rx_strobe.sv
// Input register stage for the VGA receiver: samples the pixel bus once in clk,
// finds the vga_clk rising edge and flags sync/blank transitions on that strobe.
module vga_rx_strobe #(
    parameter bit SYNC_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vga_clk,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic        vga_blank_n,
    input  logic [7:0]  vga_r,
    input  logic [7:0]  vga_g,
    input  logic [7:0]  vga_b,
    output logic        strobe,
    output logic        blank_n,
    output logic        blank_fall,
    output logic        hs_assert,
    output logic        vs_assert,
    output logic [23:0] rgb
);

    logic        clk_q_r;
    logic        clk_qq_r;
    logic        hs_q_r;
    logic        vs_q_r;
    logic        blank_q_r;
    logic [23:0] rgb_q_r;
    logic        hs_prev_r;
    logic        vs_prev_r;
    logic        blank_prev_r;
    logic        hs_act_s;
    logic        vs_act_s;

    // Register every input once; vga_clk gets a second stage for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_q_r   <= 1'b0;
            clk_qq_r  <= 1'b0;
            hs_q_r    <= 1'b0;
            vs_q_r    <= 1'b0;
            blank_q_r <= 1'b0;
            rgb_q_r   <= 24'h000000;
        end else begin
            clk_q_r   <= vga_clk;
            clk_qq_r  <= clk_q_r;
            hs_q_r    <= vga_hs;
            vs_q_r    <= vga_vs;
            blank_q_r <= vga_blank_n;
            rgb_q_r   <= {vga_r, vga_g, vga_b};
        end
    end

    assign strobe   = clk_q_r & ~clk_qq_r;
    assign hs_act_s = hs_q_r ^ SYNC_LOW;
    assign vs_act_s = vs_q_r ^ SYNC_LOW;

    // Remember sync/blank levels from the previous pixel so transitions are seen per pixel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_prev_r    <= 1'b0;
            vs_prev_r    <= 1'b0;
            blank_prev_r <= 1'b0;
        end else if (strobe) begin
            hs_prev_r    <= hs_act_s;
            vs_prev_r    <= vs_act_s;
            blank_prev_r <= blank_q_r;
        end else begin
            hs_prev_r    <= hs_prev_r;
            vs_prev_r    <= vs_prev_r;
            blank_prev_r <= blank_prev_r;
        end
    end

    assign blank_n    = blank_q_r;
    assign rgb        = rgb_q_r;
    assign blank_fall = strobe & blank_prev_r & ~blank_q_r;
    assign hs_assert  = strobe & hs_act_s & ~hs_prev_r;
    assign vs_assert  = strobe & vs_act_s & ~vs_prev_r;

endmodule

// File: rtl/vga_rx_monitor.sv
// VGA receive monitor: decodes the pixel stream back to coordinates, checks
// line/frame geometry, tracks lock, captures one probe pixel per frame.
module vga_rx_monitor
    import vga_rx_monitor_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter bit SYNC_LOW = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vga_clk,
    input  logic             vga_hs,
    input  logic             vga_vs,
    input  logic             vga_blank_n,
    input  logic [7:0]       vga_r,
    input  logic [7:0]       vga_g,
    input  logic [7:0]       vga_b,
    input  logic [9:0]       probe_x,
    input  logic [9:0]       probe_y,
    output logic             pix_valid,
    output logic [9:0]       pix_x,
    output logic [9:0]       pix_y,
    output logic [23:0]      pix_rgb,
    output logic             frame_start,
    output logic             locked,
    output logic [23:0]      probe_rgb,
    output logic             probe_done,
    output logic [CNT_W-1:0] frame_count,
    output logic [7:0]       err_count
);

    localparam logic [9:0] H_END = 10'(H_ACTIVE);
    localparam logic [9:0] V_END = 10'(V_ACTIVE);

    logic        strobe_s;
    logic        blank_n_s;
    logic        blank_fall_s;
    logic        hs_assert_s;
    logic        vs_assert_s;
    logic [23:0] rgb_s;

    rx_state_e   state_r;
    rx_state_e   state_nxt_s;
    logic        armed_r;
    logic        armed_nxt_s;
    logic        err_inc_s;
    logic        frame_inc_s;
    logic        frame_clr_s;
    logic        frame_start_s;

    logic [9:0]  x_cnt_r;
    logic [9:0]  y_cnt_r;
    logic        frame_err_r;
    logic [9:0]  probe_x_r;
    logic [9:0]  probe_y_r;
    logic        probe_hit_r;

    logic        x_over_s;
    logic        line_err_s;
    logic [9:0]  y_inc_s;
    logic [9:0]  y_eff_s;
    logic        frame_bad_s;
    logic        pix_nxt_s;
    logic        probe_fire_s;

    vga_rx_strobe #(
        .SYNC_LOW (SYNC_LOW)
    ) u_strobe (
        .clk         (clk),
        .reset       (reset),
        .vga_clk     (vga_clk),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank_n (vga_blank_n),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .strobe      (strobe_s),
        .blank_n     (blank_n_s),
        .blank_fall  (blank_fall_s),
        .hs_assert   (hs_assert_s),
        .vs_assert   (vs_assert_s),
        .rgb         (rgb_s)
    );

    // Geometry checks. A line that ends at VS is judged first, so the frame check
    // sees the row count including that line. HS inside active video is a bad line.
    assign x_over_s    = strobe_s & blank_n_s & (x_cnt_r == H_END);
    assign line_err_s  = (blank_fall_s & (x_cnt_r != H_END)) | x_over_s | (hs_assert_s & blank_n_s);
    assign y_inc_s     = (y_cnt_r == 10'h3FF) ? y_cnt_r : (y_cnt_r + 10'd1);
    assign y_eff_s     = blank_fall_s ? y_inc_s : y_cnt_r;
    assign frame_bad_s = (y_eff_s != V_END) | frame_err_r | line_err_s;

    // Next-state logic. ALIGN entered mid-frame is unarmed: the first VS only
    // marks a frame boundary, the following VS judges a complete frame.
    always_comb begin
        state_nxt_s = state_r;
        armed_nxt_s = armed_r;
        err_inc_s   = 1'b0;
        frame_inc_s = 1'b0;
        frame_clr_s = 1'b0;
        case (state_r)
            ST_SEARCH: begin
                if (vs_assert_s) begin
                    state_nxt_s = ST_ALIGN;
                    armed_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_SEARCH;
                end
            end
            ST_ALIGN: begin
                if (vs_assert_s) begin
                    if (!armed_r) begin
                        armed_nxt_s = 1'b1;
                    end else if (frame_bad_s) begin
                        err_inc_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_LOCKED;
                        frame_clr_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_ALIGN;
                end
            end
            ST_LOCKED: begin
                if (vs_assert_s) begin
                    if (frame_bad_s) begin
                        err_inc_s   = 1'b1;
                        state_nxt_s = ST_ALIGN;
                        armed_nxt_s = 1'b1;
                    end else begin
                        frame_inc_s = 1'b1;
                    end
                end else if (line_err_s) begin
                    err_inc_s   = 1'b1;
                    state_nxt_s = ST_ALIGN;
                    armed_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            default: begin
                state_nxt_s = ST_SEARCH;
                armed_nxt_s = 1'b0;
            end
        endcase
        frame_start_s = vs_assert_s & (state_nxt_s == ST_LOCKED);
    end

    assign pix_nxt_s    = strobe_s & blank_n_s & (x_cnt_r < H_END) & (y_cnt_r < V_END)
                          & (state_r == ST_LOCKED) & (state_nxt_s == ST_LOCKED);
    assign probe_fire_s = pix_nxt_s & ~probe_hit_r & (x_cnt_r == probe_x_r) & (y_cnt_r == probe_y_r);

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_SEARCH;
            armed_r <= 1'b0;
            locked  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            armed_r <= armed_nxt_s;
            locked  <= (state_nxt_s == ST_LOCKED);
        end
    end

    // Column/row counters; column holds at H_ACTIVE on an over-long line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_cnt_r     <= 10'd0;
            y_cnt_r     <= 10'd0;
            frame_err_r <= 1'b0;
        end else if (strobe_s) begin
            if (blank_fall_s) begin
                x_cnt_r <= 10'd0;
            end else if (blank_n_s && (x_cnt_r != H_END)) begin
                x_cnt_r <= x_cnt_r + 10'd1;
            end else begin
                x_cnt_r <= x_cnt_r;
            end
            if (vs_assert_s) begin
                y_cnt_r <= 10'd0;
            end else if (blank_fall_s) begin
                y_cnt_r <= y_inc_s;
            end else begin
                y_cnt_r <= y_cnt_r;
            end
            if (vs_assert_s) begin
                frame_err_r <= 1'b0;
            end else if (line_err_s) begin
                frame_err_r <= 1'b1;
            end else begin
                frame_err_r <= frame_err_r;
            end
        end else begin
            x_cnt_r     <= x_cnt_r;
            y_cnt_r     <= y_cnt_r;
            frame_err_r <= frame_err_r;
        end
    end

    // Decoded pixel outputs; coordinates and colour hold between valid pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_valid <= 1'b0;
            pix_x     <= 10'd0;
            pix_y     <= 10'd0;
            pix_rgb   <= 24'h000000;
        end else if (pix_nxt_s) begin
            pix_valid <= 1'b1;
            pix_x     <= x_cnt_r;
            pix_y     <= y_cnt_r;
            pix_rgb   <= rgb_s;
        end else begin
            pix_valid <= 1'b0;
        end
    end

    // Probe: coordinates latched per locked frame, first matching pixel captured once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            probe_x_r   <= 10'd0;
            probe_y_r   <= 10'd0;
            probe_hit_r <= 1'b0;
            probe_rgb   <= 24'h000000;
            probe_done  <= 1'b0;
        end else begin
            probe_done <= probe_fire_s;
            if (frame_start_s) begin
                probe_x_r   <= probe_x;
                probe_y_r   <= probe_y;
                probe_hit_r <= 1'b0;
            end else if (probe_fire_s) begin
                probe_hit_r <= 1'b1;
                probe_rgb   <= rgb_s;
            end else begin
                probe_hit_r <= probe_hit_r;
            end
        end
    end

    // Status: frame-start pulse, good-frame counter (restarts at lock), saturating errors.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_start <= 1'b0;
            frame_count <= '0;
            err_count   <= 8'd0;
        end else begin
            frame_start <= frame_start_s;
            if (frame_clr_s) begin
                frame_count <= '0;
            end else if (frame_inc_s) begin
                frame_count <= frame_count + CNT_W'(1);
            end else begin
                frame_count <= frame_count;
            end
            if (err_inc_s) begin
                err_count <= sat_inc8(err_count);
            end else begin
                err_count <= err_count;
            end
        end
    end

endmodule
